ft2020_ifetch: RTL and testbench

Instruction prefetch unit sitting directly upstream of the FT2020 core's instruction port. It tracks the core's `ip`, fetches sequential 32-bit instruction words from instruction memory over a single-outstanding request/acknowledge bus, and buffers them in a small queue so the core can take one instruction per clock. Any `ip` that differs from the queue's expected address flushes the queue and restarts fetching at the new address.

---
 rtl/ft2020_pkg.sv | 13 +
 rtl/ft2020_ifetch_if.sv | 16 +
 rtl/ft2020_ifq.sv | 68 ++++++
 rtl/ft2020_ifetch.sv | 110 +++++++++++
 tb/tb_ft2020_ifetch.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft2020_pkg.sv
// rtl/ft2020_pkg.sv - shared FT2020 constants and instruction-fetch state type
package ft2020_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_00EA;
  localparam int AW_DEF = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DISCARD
  } fetch_state_e;

endpackage

// File: rtl/ft2020_ifetch_if.sv
// rtl/ft2020_ifetch_if.sv - single-outstanding instruction memory request/acknowledge bus
interface ft2020_ifetch_if
  import ft2020_pkg::*;
#(
  parameter int AW = AW_DEF
);

  logic          mem_cyc;
  logic [AW-1:0] mem_adr;
  logic          mem_ack;
  logic [31:0]   mem_dat;

  modport master (output mem_cyc, mem_adr, input mem_ack, mem_dat);
  modport slave  (input mem_cyc, mem_adr, output mem_ack, mem_dat);

endinterface

// File: rtl/ft2020_ifq.sv
// rtl/ft2020_ifq.sv - {address, word} prefetch FIFO; flush wins over push and pop
module ft2020_ifq #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 25,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_adr,
  input  logic [31:0]   push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] head_adr,
  output logic [31:0]   head_dat,
  output logic [CW-1:0] cnt
);

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = '{adr: push_adr, dat: push_dat};
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_adr = mem_q[rd_q].adr;
  assign head_dat = mem_q[rd_q].dat;
  assign cnt      = cnt_q;

endmodule

// File: rtl/ft2020_ifetch.sv
// rtl/ft2020_ifetch.sv - FT2020 instruction prefetch: tracks ip, fetches ahead, flushes on redirect
module ft2020_ifetch
  import ft2020_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ip,
  input  logic            next,
  output logic [31:0]     insn,
  output logic            insn_v,
  ft2020_ifetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fadr_q, fadr_d;
  logic [AW-1:0] stale_q, stale_d;

  logic [AW-1:0] ip_w, ea, head_adr;
  logic [31:0]   head_dat;
  logic [CW-1:0] cnt, cnt_pop;
  logic          has_head, mismatch, pop, push, ack;

  assign ip_w     = {ip[AW-1:2], 2'b00};
  assign has_head = (cnt != '0);
  assign ea       = has_head ? head_adr : fadr_q;
  assign mismatch = (ip_w != ea);
  assign insn_v   = has_head && (head_adr == ip_w);
  assign insn     = insn_v ? head_dat : NOP_INSN;
  assign pop      = next && insn_v;
  assign cnt_pop  = cnt - CW'(pop);
  assign ack      = bus.mem_cyc && bus.mem_ack;

  // A redirected fetch keeps presenting the abandoned address until the memory acks it.
  assign bus.mem_cyc = (state_q != ST_IDLE);
  assign bus.mem_adr = (state_q == ST_DISCARD) ? stale_q : fadr_q;

  always_comb begin
    state_d = state_q;
    fadr_d  = fadr_q;
    stale_d = stale_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mismatch) begin
          fadr_d = ip_w;
        end else if (cnt_pop < CW'(DEPTH)) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mismatch) begin
          fadr_d = ip_w;
          if (!ack) begin
            stale_d = fadr_q;
            state_d = ST_DISCARD;
          end
        end else if (ack) begin
          push   = 1'b1;
          fadr_d = fadr_q + AW'(4);
          if (cnt_pop >= CW'(DEPTH - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (mismatch) begin
          fadr_d = ip_w;
        end
        if (ack) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fadr_q  <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      fadr_q  <= fadr_d;
      stale_q <= stale_d;
    end
  end

  ft2020_ifq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ifq (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_adr (fadr_q),
    .push_dat (bus.mem_dat),
    .pop      (pop),
    .flush    (mismatch),
    .head_adr (head_adr),
    .head_dat (head_dat),
    .cnt      (cnt)
  );

endmodule

// File: tb/tb_ft2020_ifetch.sv
// tb/tb_ft2020_ifetch.sv - scripted and randomized checks of ft2020_ifetch against a queue model
module tb_ft2020_ifetch;
  import ft2020_pkg::*;

  localparam int AW    = 25;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ip;
  logic          next;
  logic [31:0]   insn;
  logic          insn_v;

  ft2020_ifetch_if #(.AW(AW)) bus ();

  ft2020_ifetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ip     (ip),
    .next   (next),
    .insn   (insn),
    .insn_v (insn_v),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory responder controls
  int          waits   = 0;
  int          wcnt    = 0;
  logic        hold    = 1'b0;
  logic        rnd_mode = 1'b0;
  int          ack_pct = 50;
  logic [31:0] key     = 32'h0;

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return {7'b0, a} ^ key;
  endfunction

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_dat = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (rnd_mode) begin
        if (bus.mem_cyc) begin
          bus.mem_ack = ($urandom_range(0, 99) < ack_pct);
          bus.mem_dat = word_of(bus.mem_adr);
        end else begin
          bus.mem_ack = 1'($urandom_range(0, 1));
          bus.mem_dat = $urandom;
        end
      end else if (bus.mem_cyc && !hold) begin
        if (wcnt >= waits) begin
          bus.mem_ack = 1'b1;
          bus.mem_dat = word_of(bus.mem_adr);
          wcnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        if (!bus.mem_cyc) wcnt = 0;
      end
    end
  end

  // reference model: a plain queue plus the single request slot
  logic [AW-1:0] q_adr[$];
  logic [31:0]   q_dat[$];
  logic [AW-1:0] m_fadr;
  logic [AW-1:0] m_radr;
  logic          m_on;
  logic          m_stale;
  logic          m_pop;
  logic          mvalid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h, want %08h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q_adr.delete();
    q_dat.delete();
    m_fadr  = '0;
    m_radr  = '0;
    m_on    = 1'b0;
    m_stale = 1'b0;
    m_pop   = 1'b0;
  endtask

  task automatic model_step();
    logic [AW-1:0] ipw, ea;
    logic          has, mism, ev, ackd;
    logic [31:0]   einsn;
    if (!mvalid) begin
      if (rst) begin
        model_reset();
        mvalid = 1'b1;
      end
      return;
    end
    ipw   = ip & ~AW'(3);
    has   = (q_adr.size() > 0);
    ea    = has ? q_adr[0] : m_fadr;
    mism  = (ipw != ea);
    ev    = has && (q_adr[0] == ipw);
    einsn = ev ? q_dat[0] : NOP_INSN;
    chk("mdl_insn_v", 32'(insn_v), 32'(ev));
    chk("mdl_insn", insn, einsn);
    chk("mdl_mem_cyc", 32'(bus.mem_cyc), 32'(m_on));
    if (m_on) chk("mdl_mem_adr", 32'(bus.mem_adr), 32'(m_radr));
    if (rst) begin
      model_reset();
      return;
    end
    ackd  = m_on && bus.mem_ack;
    m_pop = next && ev;
    if (mism) begin
      q_adr.delete();
      q_dat.delete();
      m_fadr = ipw;
    end else if (m_pop) begin
      void'(q_adr.pop_front());
      void'(q_dat.pop_front());
    end
    if (ackd) begin
      if (!m_stale && !mism) begin
        q_adr.push_back(m_radr);
        q_dat.push_back(bus.mem_dat);
        m_fadr = m_fadr + AW'(4);
      end
      m_on    = 1'b0;
      m_stale = 1'b0;
      if (q_adr.size() < DEPTH) begin
        m_on   = 1'b1;
        m_radr = m_fadr;
      end
    end else if (m_on) begin
      if (mism) m_stale = 1'b1;
    end else if (!mism && q_adr.size() < DEPTH) begin
      m_on   = 1'b1;
      m_radr = m_fadr;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_step();
  endtask

  task automatic do_reset();
    next_cycle();
    rst  = 1'b1;
    ip   = '0;
    next = 1'b0;
    settle();
    next_cycle();
    settle();
    chk("rst_mem_cyc", 32'(bus.mem_cyc), 32'h0);
    chk("rst_mem_adr", 32'(bus.mem_adr), 32'h0);
    chk("rst_insn_v", 32'(insn_v), 32'h0);
    chk("rst_insn", insn, 32'h0000_00EA);
  endtask

  logic [AW-1:0] core_ip;
  int            r;
  int            next_pct;

  initial begin
    rst  = 1'b1;
    ip   = '0;
    next = 1'b0;

    // zero-wait sequential streaming, word = address
    do_reset();
    next_cycle(); rst = 1'b0; settle();
    chk("a_c0_cyc", 32'(bus.mem_cyc), 32'h0);
    next_cycle(); settle();
    chk("a_c1_cyc", 32'(bus.mem_cyc), 32'h1);
    chk("a_c1_adr", 32'(bus.mem_adr), 32'h0);
    chk("a_c1_v", 32'(insn_v), 32'h0);
    next_cycle(); next = 1'b1; settle();
    chk("a_c2_v", 32'(insn_v), 32'h1);
    chk("a_c2_insn", insn, 32'h0);
    for (int k = 0; k < 6; k++) begin
      chk("a_run_v", 32'(insn_v), 32'h1);
      chk("a_run_insn", insn, 32'(k * 4));
      chk("a_run_adr", 32'(bus.mem_adr), 32'(k * 4 + 4));
      next_cycle(); ip = ip + AW'(4); settle();
    end

    // three wait states
    waits = 3;
    do_reset();
    next_cycle(); rst = 1'b0; settle();
    for (int k = 1; k <= 3; k++) begin
      next_cycle(); settle();
      chk("b_wait_cyc", 32'(bus.mem_cyc), 32'h1);
      chk("b_wait_adr", 32'(bus.mem_adr), 32'h0);
    end
    next_cycle(); settle();
    chk("b_ack_v", 32'(insn_v), 32'h0);
    next_cycle(); settle();
    chk("b_v", 32'(insn_v), 32'h1);
    chk("b_insn", insn, 32'h0);
    waits = 0;

    // queue fills to DEPTH, then one pop allows exactly one refill
    do_reset();
    next_cycle(); rst = 1'b0; settle();
    repeat (4) begin next_cycle(); settle(); end
    for (int k = 0; k < 3; k++) begin
      next_cycle(); settle();
      chk("c_full_cyc", 32'(bus.mem_cyc), 32'h0);
      chk("c_full_insn", insn, 32'h0);
    end
    next_cycle(); next = 1'b1; settle();
    chk("c_pop_v", 32'(insn_v), 32'h1);
    next_cycle(); next = 1'b0; ip = 25'h4; settle();
    chk("c_refill_cyc", 32'(bus.mem_cyc), 32'h1);
    chk("c_refill_adr", 32'(bus.mem_adr), 32'h10);
    chk("c_refill_insn", insn, 32'h4);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); settle();
      chk("c_after_cyc", 32'(bus.mem_cyc), 32'h0);
    end

    // redirect 8 -> 0x100 while the fetch of 12 is stalled
    do_reset();
    next_cycle(); rst = 1'b0; next = 1'b1; settle();
    next_cycle(); settle();
    next_cycle(); settle();
    next_cycle(); ip = 25'h4; settle();
    next_cycle(); ip = 25'h8; next = 1'b0; hold = 1'b1; settle();
    chk("d_head_insn", insn, 32'h8);
    chk("d_stall_adr", 32'(bus.mem_adr), 32'hC);
    next_cycle(); ip = 25'h100; settle();
    chk("d_redir_v", 32'(insn_v), 32'h0);
    next_cycle(); settle();
    chk("d_disc_cyc", 32'(bus.mem_cyc), 32'h1);
    chk("d_disc_adr", 32'(bus.mem_adr), 32'hC);
    next_cycle(); hold = 1'b0; settle();
    chk("d_drop_v", 32'(insn_v), 32'h0);
    next_cycle(); settle();
    chk("d_new_adr", 32'(bus.mem_adr), 32'h100);
    chk("d_new_v", 32'(insn_v), 32'h0);
    next_cycle(); settle();
    chk("d_arrive_v", 32'(insn_v), 32'h1);
    chk("d_arrive_insn", insn, 32'h100);

    // fetch address wraps modulo 2^25
    do_reset();
    next_cycle(); rst = 1'b0; ip = 25'h1FF_FFF8; settle();
    next_cycle(); settle();
    chk("e_idle_cyc", 32'(bus.mem_cyc), 32'h0);
    next_cycle(); settle();
    chk("e_adr0", 32'(bus.mem_adr), 32'h1FF_FFF8);
    next_cycle(); settle();
    chk("e_insn", insn, 32'h01FF_FFF8);
    chk("e_adr1", 32'(bus.mem_adr), 32'h1FF_FFFC);
    next_cycle(); settle();
    chk("e_wrap_cyc", 32'(bus.mem_cyc), 32'h1);
    chk("e_wrap_adr", 32'(bus.mem_adr), 32'h0);

    // randomized traffic against the model
    key      = $urandom;
    rnd_mode = 1'b1;
    core_ip  = ip;
    next_pct = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      next_cycle();
      if (cyc % 250 == 0) begin
        ack_pct  = $urandom_range(20, 100);
        next_pct = $urandom_range(10, 100);
      end
      if (m_pop) core_ip = core_ip + AW'(4);
      r = $urandom_range(0, 199);
      if (r < 8) begin
        case ($urandom_range(0, 2))
          0:       core_ip = AW'({$urandom_range(0, 15), 2'b00});
          1:       core_ip = AW'(25'h100 + {$urandom_range(0, 15), 2'b00});
          default: core_ip = AW'(25'h1FF_FFE0 + {$urandom_range(0, 7), 2'b00});
        endcase
      end
      rst  = (r == 199);
      next = ($urandom_range(0, 99) < next_pct);
      ip   = core_ip | (($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 3)) : AW'(0));
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
